// File: rtl/tlb_reader.sv
// tlb_reader: services CP0 tlbr/tlbp requests against a 16-entry TLB array.
//   tlbr reads the indexed entry; tlbp scans entries 0..15 for a VPN2 match,
//   with the lowest matching index winning.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in idle)
//   req_op                0 = tlbr, 1 = tlbp
//   req_index, req_vpn2   tlbr index / tlbp key
//   abort                 pipeline flush, cancels in-flight work
//   tlbwi                 array is being written this cycle
//   ent_idx, ent_data     array read port (combinational data)
//   resp_valid            one-cycle result strobe
//   resp_config           {entry[70:0], index[3:0]}
//   resp_probe_fail       tlbp found no match
module tlb_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_op,
    input  logic [3:0]  req_index,
    input  logic [18:0] req_vpn2,
    output logic        req_ready,
    input  logic        abort,
    input  logic        tlbwi,
    output logic [3:0]  ent_idx,
    input  logic [70:0] ent_data,
    output logic        resp_valid,
    output logic [74:0] resp_config,
    output logic        resp_probe_fail
);

    typedef enum logic [1:0] {StIdle, StRead, StScan, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  index_q, index_d;
    logic [18:0] vpn_q, vpn_d;
    logic [74:0] cfg_q, cfg_d;
    logic        fail_q, fail_d;

    logic accept;
    logic match;

    assign accept = (state_q == StIdle) && req_valid && !abort;
    // V/D bits live below bit 52, so only the VPN2 field takes part.
    assign match  = (ent_data[70:52] == vpn_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: abort beats tlbwi beats normal progress.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = req_op ? StScan : StRead;
                end
            end
            StRead: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (!tlbwi) begin
                    state_d = StResp;
                end
            end
            StScan: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (!tlbwi && (match || cnt_q == 4'd15)) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready  = (state_q == StIdle) && !rst;
        resp_valid = (state_q == StResp) && !abort && !rst;
        ent_idx    = 4'd0;
        if (state_q == StRead) begin
            ent_idx = index_q;
        end else if (state_q == StScan) begin
            ent_idx = cnt_q;
        end
    end

    assign resp_config     = cfg_q;
    assign resp_probe_fail = fail_q;

    // Datapath next state
    always_comb begin
        cnt_d   = cnt_q;
        index_d = index_q;
        vpn_d   = vpn_q;
        cfg_d   = cfg_q;
        fail_d  = fail_q;
        if (accept) begin
            index_d = req_index;
            vpn_d   = req_vpn2;
            cnt_d   = 4'd0;
        end else if (!abort && !tlbwi && state_q == StRead) begin
            cfg_d  = {ent_data, index_q};
            fail_d = 1'b0;
        end else if (!abort && state_q == StScan) begin
            if (tlbwi) begin
                // Array changed under us: restart so the result reflects the new contents.
                cnt_d = 4'd0;
            end else if (match) begin
                cfg_d  = {ent_data, cnt_q};
                fail_d = 1'b0;
            end else if (cnt_q == 4'd15) begin
                cfg_d  = '0;
                fail_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 4'd0;
            index_q <= 4'd0;
            vpn_q   <= 19'd0;
            cfg_q   <= 75'd0;
            fail_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            index_q <= index_d;
            vpn_q   <= vpn_d;
            cfg_q   <= cfg_d;
            fail_q  <= fail_d;
        end
    end

endmodule

// File: doc/tlb_reader.md
TLB_READER -- requirements
Module: tlb_reader

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 req_valid  input  1  request strobe from CP0 (tlbr/tlbp issue).
REQ-004 req_op  input  1  0 = tlbr (read indexed entry), 1 = tlbp (probe by VPN2).
REQ-005 req_index  input  4  entry index for tlbr; ignored for tlbp.
REQ-006 req_vpn2  input  19  VPN2 key for tlbp; ignored for tlbr.
REQ-007 req_ready  output  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high on a rising edge.
REQ-008 abort  input  1  pipeline flush; cancels any in-flight request.
REQ-009 tlbwi  input  1  the TLB array is being written this cycle.
REQ-010 ent_idx  output  4  read address into the TLB entry array.
REQ-011 ent_data  input  71  combinational array read data: {vpn2[70:52], pfn1[51:28], d1[27], v1[26], pfn0[25:2], d0[1], v0[0]}.
REQ-012 resp_valid  output  1  one-cycle result strobe.
REQ-013 resp_config  output  75  {ent_data[70:0], index[3:0]}; same layout as the CP0 tlbConfig bus.
REQ-014 resp_probe_fail  output  1  tlbp found no matching entry; always 0 for tlbr.

Function
REQ-015 The state machine has four states: IDLE, READ, SCAN and RESP.
REQ-016 IDLE: on accept, latch req_op, req_index and req_vpn2, then go to READ if req_op=0 or to SCAN with scan counter=0 if req_op=1.
REQ-017 READ: drive ent_idx=latched index, capture ent_data into the result register, go to RESP.
REQ-018 SCAN: drive ent_idx=counter and compare ent_data[70:52] with the latched VPN2; the compare ignores the V and D bits.
REQ-019 SCAN on a match: capture ent_data and the counter, clear the fail flag, go to RESP; the lowest matching index wins.
REQ-020 SCAN with no match and counter<15: increment the counter and stay in SCAN.
REQ-021 SCAN with no match and counter=15: set the result to all zeros, set the fail flag, go to RESP.
REQ-022 RESP: assert resp_valid for exactly one cycle with the registered result, then return to IDLE; the result is held until the next capture.
REQ-023 Latency from accept edge T0 for tlbr: resp_valid is high in cycle T0+2.
REQ-024 Latency for a tlbp match at index k: resp_valid is high in cycle T0+k+2.
REQ-025 Latency for a tlbp miss: resp_valid is high in cycle T0+17.
REQ-026 tlbwi high in a READ cycle: discard the capture and stay in READ, so the entry is re-read in the next cycle.
REQ-027 tlbwi high in a SCAN cycle: discard any match, reset the counter to 0 and stay in SCAN.
REQ-028 tlbwi high in IDLE or RESP has no effect.
REQ-029 abort high in READ, SCAN or RESP: go to IDLE next cycle; resp_valid is 0 in that cycle and in the next.
REQ-030 abort in IDLE blocks acceptance in that same cycle.
REQ-031 Priority, highest first: rst, abort, tlbwi, normal progress.
REQ-032 Back-to-back requests: the earliest a new request is accepted is the cycle after RESP.
REQ-033 ent_idx is 0 in IDLE and RESP.

Reset
REQ-034 While rst is high: state=IDLE, counter=0, result register=0, fail flag=0, resp_valid=0, req_ready=0.
REQ-035 In the first cycle after rst deasserts, req_ready=1.
REQ-036 rst asserted mid-READ or mid-SCAN drops the request with no resp_valid.

Verification
REQ-037 Scenario: tlbr with req_index=5, entry 5 = 71'h1_2345_6789_ABCD_EF01_2 -> resp_valid at T0+2; resp_config = {that entry, 4'h5}; resp_probe_fail=0.
REQ-038 Scenario: tlbp with req_vpn2=19'h4_0001, present at indices 3 and 9 -> resp_valid at T0+5; index=3; resp_probe_fail=0.
REQ-039 Scenario: tlbp with req_vpn2=19'h7_FFFF, no matching entry -> resp_valid at T0+17; resp_config=0; resp_probe_fail=1.
REQ-040 Scenario: tlbp with tlbwi pulsed while scanning index 6, the write moving the key to index 2 -> scan restarts and reports index 2.
REQ-041 Scenario: abort pulsed at T0+4 of a tlbp -> no resp_valid; req_ready=1 at T0+5.
REQ-042 Scenario: rst asserted during SCAN, then a tlbr issued after release -> the tlbr completes normally in 2 cycles.
